hero_write_rx: RTL and testbench

HERO_WRITE_RX -- requirements
Module: hero_write_rx

---
 rtl/hero_write_rx_pkg.sv | 31 +++
 rtl/hero_write_rx_mem.sv | 26 ++
 rtl/hero_write_rx.sv | 153 +++++++++++++++
 tb/tb_hero_write_rx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hero_write_rx_pkg.sv
// Shared hero bus types plus receive-side state and entry definitions for hero_write_rx.
package hero_write_rx_pkg;

    localparam int HERO_WIDTH          = 36;
    localparam int HERO_RX_ENTRY_WIDTH = HERO_WIDTH + 1;

    // Encoding 2'd3 is unused on the bus and treated as a bubble.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        DONE  = 2'd2
    } CYCLE_TYPE_E;

    typedef struct packed {
        logic                  clk_en;
        CYCLE_TYPE_E           cycle_type;
        logic [HERO_WIDTH-1:0] wdat;
        logic [20:0]           another_type_reference;
    } hero_write_t;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_COLLECT = 2'd1,
        RX_DROP    = 2'd2
    } hero_rx_state_e;

    function automatic logic is_beat(input hero_write_t h);
        return h.clk_en && (h.cycle_type == VALID || h.cycle_type == DONE);
    endfunction

endpackage

// File: rtl/hero_write_rx_mem.sv
// Beat storage for hero_write_rx: one write port, one asynchronous read port, no pointer logic.
module hero_write_rx_mem
    import hero_write_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [AW-1:0]                  waddr,
    input  logic [HERO_RX_ENTRY_WIDTH-1:0] wdata,
    input  logic [AW-1:0]                  raddr,
    output logic [HERO_RX_ENTRY_WIDTH-1:0] rdata
);

    logic [HERO_RX_ENTRY_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hero_write_rx.sv
// Hero write receiver: stores beats speculatively, exposes only committed transactions.
// Optional HERO_WRITE_RX_STATS_EN adds saturating committed/dropped transaction counters.
module hero_write_rx
    import hero_write_rx_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int MAX_BEATS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  hero_write_t           hero_write,
    output logic                  rd_vld,
    input  logic                  rd_rdy,
    output logic [HERO_WIDTH-1:0] rd_dat,
    output logic                  rd_last,
    output logic                  ovf_err,
    output logic                  proto_err,
`ifdef HERO_WRITE_RX_STATS_EN
    output logic [15:0]           rx_txn_cnt,
    output logic [15:0]           drop_txn_cnt,
`endif
    output hero_rx_state_e        state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [CW-1:0] MAX_P   = CW'(MAX_BEATS);

    hero_rx_state_e state, state_n;
    logic [PW-1:0] wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr;
    logic [CW-1:0] beat_cnt, beat_cnt_n;
    logic          beat, is_done, full, we, commit, drop;
    logic          ovf_n, proto_n, ovf_q, proto_q;
    logic [HERO_RX_ENTRY_WIDTH-1:0] rdata;
    logic          unused_atr;

    assign unused_atr = ^hero_write.another_type_reference;

    always_comb begin
        state_n      = state;
        wr_ptr_n     = wr_ptr;
        commit_ptr_n = commit_ptr;
        beat_cnt_n   = beat_cnt;
        we           = 1'b0;
        commit       = 1'b0;
        drop         = 1'b0;
        ovf_n        = 1'b0;
        proto_n      = 1'b0;
        beat         = is_beat(hero_write);
        is_done      = (hero_write.cycle_type == DONE);
        // Occupancy includes speculative beats and ignores a read on the same edge.
        full         = ((wr_ptr - rd_ptr) == DEPTH_P);
        if (beat) begin
            case (state)
                RX_IDLE, RX_COLLECT: begin
                    if (full) begin
                        ovf_n      = 1'b1;
                        drop       = 1'b1;
                        wr_ptr_n   = commit_ptr;
                        beat_cnt_n = '0;
                        state_n    = is_done ? RX_IDLE : RX_DROP;
                    end else if (beat_cnt == MAX_P) begin
                        proto_n    = 1'b1;
                        drop       = 1'b1;
                        wr_ptr_n   = commit_ptr;
                        beat_cnt_n = '0;
                        state_n    = RX_DROP;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_n = wr_ptr + PW'(1);
                        if (is_done) begin
                            commit       = 1'b1;
                            commit_ptr_n = wr_ptr + PW'(1);
                            beat_cnt_n   = '0;
                            state_n      = RX_IDLE;
                        end else begin
                            beat_cnt_n = beat_cnt + CW'(1);
                            state_n    = RX_COLLECT;
                        end
                    end
                end
                RX_DROP: begin
                    if (is_done) begin
                        state_n = RX_IDLE;
                    end
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            beat_cnt   <= '0;
            ovf_q      <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            state      <= state_n;
            wr_ptr     <= wr_ptr_n;
            commit_ptr <= commit_ptr_n;
            beat_cnt   <= beat_cnt_n;
            ovf_q      <= ovf_n;
            proto_q    <= proto_n;
            if (rd_vld && rd_rdy) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

`ifdef HERO_WRITE_RX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_txn_cnt   <= '0;
            drop_txn_cnt <= '0;
        end else begin
            if (commit && rx_txn_cnt != 16'hffff) begin
                rx_txn_cnt <= rx_txn_cnt + 16'd1;
            end
            if (drop && drop_txn_cnt != 16'hffff) begin
                drop_txn_cnt <= drop_txn_cnt + 16'd1;
            end
        end
    end
`endif

    hero_write_rx_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({is_done, hero_write.wdat}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    // Read handshake: a beat transfers on any rising edge where rd_vld && rd_rdy; while
    // rd_vld is high and rd_rdy low, rd_dat/rd_last hold because the head entry cannot be rewritten.
    assign rd_vld    = !rst && (rd_ptr != commit_ptr);
    assign rd_dat    = rdata[HERO_WIDTH-1:0];
    assign rd_last   = rd_vld && rdata[HERO_WIDTH];
    assign ovf_err   = ovf_q && !rst;
    assign proto_err = proto_q && !rst;
    assign state_dbg = state;

endmodule

// File: tb/tb_hero_write_rx.sv
// Bench for hero_write_rx: directed scenarios with literal checks, then random traffic against a queue model.
module tb_hero_write_rx;
    import hero_write_rx_pkg::*;

    localparam int DEPTH     = 16;
    localparam int MAX_BEATS = 8;
    localparam int E         = HERO_RX_ENTRY_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    hero_write_t           hero_write;
    logic                  rd_vld;
    logic                  rd_rdy;
    logic [HERO_WIDTH-1:0] rd_dat;
    logic                  rd_last;
    logic                  ovf_err;
    logic                  proto_err;
    hero_rx_state_e        state_dbg;
`ifdef HERO_WRITE_RX_STATS_EN
    logic [15:0]           rx_txn_cnt;
    logic [15:0]           drop_txn_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference model: committed beats visible to the reader, and the beats of the open transaction.
    logic [E-1:0] exp_q[$];
    logic [E-1:0] pend_q[$];
    bit           dropping = 1'b0;
    bit           m_ovf    = 1'b0;
    bit           m_proto  = 1'b0;
    int           m_rx     = 0;
    int           m_drop   = 0;

    hero_write_rx #(
        .DEPTH     (DEPTH),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hero_write   (hero_write),
        .rd_vld       (rd_vld),
        .rd_rdy       (rd_rdy),
        .rd_dat       (rd_dat),
        .rd_last      (rd_last),
        .ovf_err      (ovf_err),
        .proto_err    (proto_err),
`ifdef HERO_WRITE_RX_STATS_EN
        .rx_txn_cnt   (rx_txn_cnt),
        .drop_txn_cnt (drop_txn_cnt),
`endif
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  occ;
        bit  b;
        bit  d;
        if (rst) begin
            exp_q.delete();
            pend_q.delete();
            dropping = 1'b0;
            m_ovf    = 1'b0;
            m_proto  = 1'b0;
            m_rx     = 0;
            m_drop   = 0;
            return;
        end
        occ = exp_q.size() + pend_q.size();
        if (rd_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        m_ovf   = 1'b0;
        m_proto = 1'b0;
        b = hero_write.clk_en && (hero_write.cycle_type == VALID || hero_write.cycle_type == DONE);
        d = (hero_write.cycle_type == DONE);
        if (b) begin
            if (dropping) begin
                if (d) dropping = 1'b0;
            end else if (occ == DEPTH) begin
                m_ovf = 1'b1;
                pend_q.delete();
                dropping = !d;
                if (m_drop < 65535) m_drop++;
            end else if (pend_q.size() == MAX_BEATS) begin
                m_proto = 1'b1;
                pend_q.delete();
                dropping = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else begin
                pend_q.push_back({d, hero_write.wdat});
                if (d) begin
                    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                    pend_q.delete();
                    if (m_rx < 65535) m_rx++;
                end
            end
        end
    endtask

    task automatic compare();
        bit             exp_vld;
        logic [E-1:0]   head;
        hero_rx_state_e exp_state;
        exp_vld   = !rst && exp_q.size() > 0;
        exp_state = dropping ? RX_DROP : (pend_q.size() > 0 ? RX_COLLECT : RX_IDLE);
        chk("rd_vld", 64'(rd_vld), 64'(exp_vld));
        if (exp_vld) begin
            head = exp_q[0];
            chk("rd_dat", 64'(rd_dat), 64'(head[HERO_WIDTH-1:0]));
            chk("rd_last", 64'(rd_last), 64'(head[HERO_WIDTH]));
        end else begin
            chk("rd_last_idle", 64'(rd_last), 64'(0));
        end
        chk("ovf_err", 64'(ovf_err), 64'(!rst && m_ovf));
        chk("proto_err", 64'(proto_err), 64'(!rst && m_proto));
        chk("state", 64'(state_dbg), 64'(exp_state));
`ifdef HERO_WRITE_RX_STATS_EN
        chk("rx_txn_cnt", 64'(rx_txn_cnt), 64'(m_rx));
        chk("drop_txn_cnt", 64'(drop_txn_cnt), 64'(m_drop));
`endif
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) compare();
    end

    task automatic set_idle();
        hero_write.clk_en     = 1'b0;
        hero_write.cycle_type = IDLE;
    endtask

    // Present one bus cycle and return just after the edge that samples it.
    task automatic cyc(input logic ce, input CYCLE_TYPE_E ct, input logic [HERO_WIDTH-1:0] d);
        hero_write.clk_en                 = ce;
        hero_write.cycle_type             = ct;
        hero_write.wdat                   = d;
        hero_write.another_type_reference = 21'($urandom);
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge with rd_rdy=1: check the head beat, then let it be consumed.
    task automatic expect_head(input logic [HERO_WIDTH-1:0] d, input logic l);
        @(negedge clk);
        chk("head_vld", 64'(rd_vld), 64'(1));
        chk("head_dat", 64'(rd_dat), 64'(d));
        chk("head_last", 64'(rd_last), 64'(l));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        rd_rdy     = 1'b0;
        hero_write = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_rd_vld", 64'(rd_vld), 64'(0));
        chk("reset_ovf", 64'(ovf_err), 64'(0));
        chk("reset_proto", 64'(proto_err), 64'(0));
        chk("reset_rd_last", 64'(rd_last), 64'(0));
        chk("reset_state", 64'(state_dbg), 64'(RX_IDLE));
        rst = 1'b0;

        // Single DONE beat: visible one cycle after sampling.
        repeat (6) cyc(1'b0, IDLE, '0);
        cyc(1'b1, DONE, 36'h5);
        @(negedge clk);
        chk("done1_vld", 64'(rd_vld), 64'(1));
        chk("done1_dat", 64'(rd_dat), 64'(36'h5));
        chk("done1_last", 64'(rd_last), 64'(1));
        rd_rdy = 1'b1;
        repeat (2) cyc(1'b0, IDLE, '0);

        // Bubbles inside a transaction are ignored; nothing visible until DONE.
        rd_rdy = 1'b0;
        cyc(1'b1, VALID, 36'h1);
        @(negedge clk);
        chk("bub_vld_a", 64'(rd_vld), 64'(0));
        cyc(1'b1, IDLE, 36'hf0);
        cyc(1'b0, VALID, 36'hf1);
        cyc(1'b1, VALID, 36'h2);
        @(negedge clk);
        chk("bub_vld_b", 64'(rd_vld), 64'(0));
        cyc(1'b1, DONE, 36'h3);
        rd_rdy = 1'b1;
        set_idle();
        expect_head(36'h1, 1'b0);
        expect_head(36'h2, 1'b0);
        expect_head(36'h3, 1'b1);
        @(negedge clk);
        chk("bub_drained", 64'(rd_vld), 64'(0));

        // Overflow: 8-beat then 9-beat transaction with the reader stalled.
        rd_rdy = 1'b0;
        for (int i = 0; i < 7; i++) cyc(1'b1, VALID, 36'h100 + 36'(i));
        cyc(1'b1, DONE, 36'h107);
        for (int i = 0; i < 8; i++) cyc(1'b1, VALID, 36'h200 + 36'(i));
        cyc(1'b1, DONE, 36'h208);
        @(negedge clk);
        chk("ovf_pulse", 64'(ovf_err), 64'(1));
        chk("ovf_no_proto", 64'(proto_err), 64'(0));
        chk("ovf_state", 64'(state_dbg), 64'(RX_IDLE));
        cyc(1'b1, DONE, 36'haa);
        rd_rdy = 1'b1;
        set_idle();
        for (int i = 0; i < 8; i++) expect_head(36'h100 + 36'(i), i == 7);
        expect_head(36'haa, 1'b1);
        @(negedge clk);
        chk("ovf_drained", 64'(rd_vld), 64'(0));

        // Beat limit: ninth beat is a protocol error; the closing DONE returns to idle.
        rd_rdy = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b1, VALID, 36'h300 + 36'(i));
        cyc(1'b1, VALID, 36'h308);
        @(negedge clk);
        chk("proto_pulse", 64'(proto_err), 64'(1));
        chk("proto_no_ovf", 64'(ovf_err), 64'(0));
        chk("proto_state", 64'(state_dbg), 64'(RX_DROP));
        cyc(1'b1, DONE, 36'h309);
        @(negedge clk);
        chk("proto_idle", 64'(state_dbg), 64'(RX_IDLE));
        chk("proto_nothing", 64'(rd_vld), 64'(0));

        // Reset in the middle of a transaction discards it.
        for (int i = 0; i < 3; i++) cyc(1'b1, VALID, 36'h500 + 36'(i));
        rst = 1'b1;
        cyc(1'b1, DONE, 36'h55);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_vld", 64'(rd_vld), 64'(0));
        chk("rst_mid_state", 64'(state_dbg), 64'(RX_IDLE));
        cyc(1'b1, DONE, 36'h77);
        rd_rdy = 1'b1;
        set_idle();
        expect_head(36'h77, 1'b1);

        // Full storage with a read on the same edge still overflows.
        rd_rdy = 1'b0;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 7; i++) cyc(1'b1, VALID, 36'h400 + 36'(t * 16 + i));
            cyc(1'b1, DONE, 36'h400 + 36'(t * 16 + 7));
        end
        rd_rdy = 1'b1;
        cyc(1'b1, VALID, 36'h4ff);
        @(negedge clk);
        chk("full_rd_ovf", 64'(ovf_err), 64'(1));
`ifdef HERO_WRITE_RX_STATS_EN
        chk("stats_drop", 64'(drop_txn_cnt), 64'(1));
        chk("stats_rx", 64'(rx_txn_cnt), 64'(3));
`endif
        cyc(1'b1, DONE, 36'h4fe);
        repeat (20) cyc(1'b0, IDLE, '0);
        @(negedge clk);
        chk("full_drained", 64'(rd_vld), 64'(0));

        // Random traffic: alternating phases of eager and sluggish reader.
        for (int n = 0; n < 4000; n++) begin
            int          r;
            CYCLE_TYPE_E ct;
            rst    = ($urandom_range(0, 599) == 0);
            rd_rdy = ((n % 1000) < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            r      = $urandom_range(0, 9);
            if (r == 0)      ct = IDLE;
            else if (r == 1) ct = CYCLE_TYPE_E'(2'd3);
            else if (r <= 7) ct = VALID;
            else             ct = DONE;
            cyc($urandom_range(0, 7) != 0, ct, 36'({$urandom, $urandom}));
        end
        rst    = 1'b0;
        rd_rdy = 1'b1;
        repeat (40) cyc(1'b0, IDLE, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
